// File: rtl/downsample_engine.sv
// rtl/downsample_engine.sv - F x F tile decimate / box-average engine on a shared DRAM port
// Walks the source image tile by tile and writes one reduced pixel per tile.
module downsample_engine #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 17,
  parameter int IMG_W       = 256,
  parameter int IMG_H       = 256,
  parameter int FACTOR_LOG2 = 1,
  parameter int SRC_BASE    = 0,
  parameter int DST_BASE    = 65536
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  localparam int F     = 1 << FACTOR_LOG2;
  localparam int OW    = IMG_W / F;
  localparam int OH    = IMG_H / F;
  localparam int ACC_W = DATA_W + 2 * FACTOR_LOG2;

  localparam logic [1:0]        D_LAST  = 2'(F - 1);
  localparam logic [ADDR_W-1:0] OX_LAST = ADDR_W'(OW - 1);
  localparam logic [ADDR_W-1:0] OY_LAST = ADDR_W'(OH - 1);
  localparam logic [ADDR_W-1:0] SRC_A   = ADDR_W'(SRC_BASE);
  localparam logic [ADDR_W-1:0] DST_A   = ADDR_W'(DST_BASE);
  localparam logic [ADDR_W-1:0] IMG_W_A = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] OW_A    = ADDR_W'(OW);
  localparam logic [ADDR_W-1:0] ONE_A   = ADDR_W'(1);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_CAPTURE, S_WRITE, S_DONE} state_t;

  state_t             state_q, state_d;
  logic               mode_q, mode_d;
  logic [ADDR_W-1:0]  ox_q, ox_d, oy_q, oy_d;
  logic [1:0]         dx_q, dx_d, dy_q, dy_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               we_q, we_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               tile_last;
  logic [ADDR_W-1:0]  src_addr, dst_addr;

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    ox_d      = ox_q;
    oy_d      = oy_q;
    dx_d      = dx_q;
    dy_d      = dy_q;
    acc_d     = acc_q;
    tile_last = !mode_q || (dx_q == D_LAST && dy_q == D_LAST);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ISSUE;
          mode_d  = mode;
          ox_d    = '0;
          oy_d    = '0;
          dx_d    = '0;
          dy_d    = '0;
          acc_d   = '0;
        end
      end
      S_ISSUE: state_d = S_CAPTURE;
      S_CAPTURE: begin
        acc_d = (dx_q == 2'd0 && dy_q == 2'd0) ? ACC_W'(mem_rdata)
                                                 : acc_q + ACC_W'(mem_rdata);
        if (tile_last) begin
          state_d = S_WRITE;
        end else begin
          state_d = S_ISSUE;
          if (dx_q == D_LAST) begin
            dx_d = 2'd0;
            dy_d = dy_q + 2'd1;
          end else begin
            dx_d = dx_q + 2'd1;
          end
        end
      end
      S_WRITE: begin
        dx_d = 2'd0;
        dy_d = 2'd0;
        if (ox_q == OX_LAST) begin
          ox_d = '0;
          oy_d = oy_q + ONE_A;
        end else begin
          ox_d = ox_q + ONE_A;
        end
        state_d = (ox_q == OX_LAST && oy_q == OY_LAST) ? S_DONE : S_ISSUE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (abort && state_q != S_IDLE) state_d = S_IDLE;
  end

  // Outputs are registered, so they are derived from the next state and next counters.
  always_comb begin
    busy_d   = (state_d != S_IDLE);
    done_d   = (state_d == S_DONE);
    we_d     = (state_d == S_WRITE);
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    src_addr = SRC_A + (((oy_d << FACTOR_LOG2) + ADDR_W'(dy_d)) * IMG_W_A)
             + (ox_d << FACTOR_LOG2) + ADDR_W'(dx_d);
    dst_addr = DST_A + oy_d * OW_A + ox_d;
    case (state_d)
      S_IDLE:  addr_d = '0;
      S_ISSUE: addr_d = src_addr;
      S_WRITE: begin
        addr_d  = dst_addr;
        wdata_d = mode_q ? DATA_W'(acc_d >> (2 * FACTOR_LOG2)) : DATA_W'(acc_d);
      end
      default: addr_d = addr_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      mode_q  <= 1'b0;
      ox_q    <= '0;
      oy_q    <= '0;
      dx_q    <= '0;
      dy_q    <= '0;
      acc_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      ox_q    <= ox_d;
      oy_q    <= oy_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      acc_q   <= acc_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign mem_addr  = addr_q;
  assign mem_we    = we_q;
  assign mem_wdata = wdata_q;
endmodule

// File: tb/tb_downsample_engine.sv
// tb/tb_downsample_engine.sv - randomized self-checking bench for downsample_engine
// Two instances (4x4 F=2 and 8x8 F=4) are checked against a tile-reduction model.
module tb_downsample_engine;
  localparam int AW   = 8;
  localparam int W0   = 4;
  localparam int FL0  = 1;
  localparam int DST0 = 16;
  localparam int W1   = 8;
  localparam int FL1  = 2;
  localparam int DST1 = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start_s [2];
  logic          mode_s  [2];
  logic          abort_s [2];
  logic          busy_s  [2];
  logic          done_s  [2];
  logic          we_s    [2];
  logic [AW-1:0] addr_s  [2];
  logic [7:0]    wdata_s [2];
  logic [7:0]    rdata_s [2];
  logic [7:0]    src     [2][64];
  int            n_checks = 0;
  int            n_errs   = 0;

  always #5 clk = ~clk;

  downsample_engine #(.DATA_W(8), .ADDR_W(AW), .IMG_W(W0), .IMG_H(W0), .FACTOR_LOG2(FL0),
                      .SRC_BASE(0), .DST_BASE(DST0)) dut0 (
    .clk(clk), .rst(rst), .start(start_s[0]), .mode(mode_s[0]), .abort(abort_s[0]),
    .busy(busy_s[0]), .done(done_s[0]), .mem_addr(addr_s[0]), .mem_we(we_s[0]),
    .mem_wdata(wdata_s[0]), .mem_rdata(rdata_s[0])
  );

  downsample_engine #(.DATA_W(8), .ADDR_W(AW), .IMG_W(W1), .IMG_H(W1), .FACTOR_LOG2(FL1),
                      .SRC_BASE(0), .DST_BASE(DST1)) dut1 (
    .clk(clk), .rst(rst), .start(start_s[1]), .mode(mode_s[1]), .abort(abort_s[1]),
    .busy(busy_s[1]), .done(done_s[1]), .mem_addr(addr_s[1]), .mem_we(we_s[1]),
    .mem_wdata(wdata_s[1]), .mem_rdata(rdata_s[1])
  );

  // One-cycle read latency DRAM; writes are observed directly from the write strobes.
  always @(posedge clk) begin
    for (int u = 0; u < 2; u++)
      rdata_s[u] <= (addr_s[u] < 8'd64) ? src[u][addr_s[u][5:0]] : 8'h00;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int img_w(input int u);
    return (u == 0) ? W0 : W1;
  endfunction

  function automatic int flog(input int u);
    return (u == 0) ? FL0 : FL1;
  endfunction

  function automatic int dst_base(input int u);
    return (u == 0) ? DST0 : DST1;
  endfunction

  // Called at a negedge; start is driven immediately, so chained calls run back to back.
  task automatic run_job(input int u, input bit md, input int fill, input int abort_at,
                         input int restart_at, input bit abort_with_start);
    int    w, f, ow, n, s, per, exp_done, limit, nexp, acc;
    int    exp_val[$];
    int    wr_addr[$];
    int    wr_data[$];
    int    wr_cyc[$];
    int    done_cyc, done_cnt, busy_cnt, last_busy, consec;
    bit    prev_we;
    string t;
    w  = img_w(u);
    f  = 1 << flog(u);
    ow = w / f;
    n  = ow * ow;
    s  = md ? f * f : 1;
    per = 2 * s + 1;
    exp_done = n * per + 1;
    t = $sformatf("u%0d m%0d f%0d a%0d", u, md, fill, abort_at);

    for (int i = 0; i < w * w; i++)
      src[u][i] = (fill == 0) ? 8'(i) : (fill == 1) ? 8'hff : 8'($urandom);
    for (int oy = 0; oy < ow; oy++) begin
      for (int ox = 0; ox < ow; ox++) begin
        acc = 0;
        if (md) begin
          for (int dy = 0; dy < f; dy++)
            for (int dx = 0; dx < f; dx++)
              acc += int'(src[u][(oy * f + dy) * w + ox * f + dx]);
          acc = acc / (f * f);
        end else begin
          acc = int'(src[u][(oy * f) * w + ox * f]);
        end
        exp_val.push_back(acc);
      end
    end

    limit = (abort_at > 0) ? abort_at + 3 : exp_done + 1;
    nexp  = (abort_at > 0) ? abort_at / per : n;
    done_cyc = 0; done_cnt = 0; busy_cnt = 0; last_busy = 0; consec = 0; prev_we = 1'b0;

    start_s[u] = 1'b1;
    mode_s[u]  = md;
    abort_s[u] = abort_with_start;
    @(negedge clk);
    start_s[u] = 1'b0;
    abort_s[u] = 1'b0;
    mode_s[u]  = ~md;
    for (int c = 1; c <= limit; c++) begin
      if (c > 1) @(negedge clk);
      if (busy_s[u]) begin
        busy_cnt++;
        last_busy = c;
      end
      if (done_s[u]) begin
        done_cnt++;
        done_cyc = c;
      end
      if (we_s[u]) begin
        if (prev_we) consec++;
        wr_addr.push_back(int'(addr_s[u]));
        wr_data.push_back(int'(wdata_s[u]));
        wr_cyc.push_back(c);
      end
      prev_we    = we_s[u];
      abort_s[u] = (c == abort_at);
      start_s[u] = (c == restart_at);
    end
    abort_s[u] = 1'b0;
    start_s[u] = 1'b0;

    if (abort_at > 0) begin
      check({t, " done_pulses"}, done_cnt, 0);
      check({t, " busy_last"}, last_busy, abort_at);
    end else begin
      check({t, " done_cycle"}, done_cyc, exp_done);
      check({t, " done_pulses"}, done_cnt, 1);
      check({t, " busy_last"}, last_busy, exp_done);
    end
    check({t, " busy_contig"}, busy_cnt, last_busy);
    check({t, " we_count"}, wr_addr.size(), nexp);
    check({t, " we_consec"}, consec, 0);
    for (int k = 0; k < wr_addr.size() && k < nexp; k++) begin
      check($sformatf("%s wr%0d addr", t, k), wr_addr[k], dst_base(u) + k);
      check($sformatf("%s wr%0d data", t, k), wr_data[k], exp_val[k]);
      check($sformatf("%s wr%0d cycle", t, k), wr_cyc[k], (k + 1) * per);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int u = 0; u < 2; u++) begin
      check($sformatf("%s u%0d busy", tag, u), int'(busy_s[u]), 0);
      check($sformatf("%s u%0d done", tag, u), int'(done_s[u]), 0);
      check($sformatf("%s u%0d we", tag, u), int'(we_s[u]), 0);
      check($sformatf("%s u%0d addr", tag, u), int'(addr_s[u]), 0);
      check($sformatf("%s u%0d wdata", tag, u), int'(wdata_s[u]), 0);
    end
  endtask

  initial begin
    for (int u = 0; u < 2; u++) begin
      start_s[u] = 1'b0;
      mode_s[u]  = 1'b0;
      abort_s[u] = 1'b0;
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    rst = 1'b0;
    @(negedge clk);

    run_job(0, 1'b1, 0, 0, 0, 1'b0);
    run_job(0, 1'b0, 0, 0, 0, 1'b0);
    run_job(1, 1'b1, 1, 0, 0, 1'b0);
    run_job(0, 1'b1, 0, 0, 5, 1'b0);
    run_job(0, 1'b1, 0, 12, 0, 1'b0);
    run_job(0, 1'b1, 0, 0, 0, 1'b1);

    // Asynchronous reset in the middle of the second CAPTURE of a job.
    start_s[0] = 1'b1;
    mode_s[0]  = 1'b1;
    @(negedge clk);
    start_s[0] = 1'b0;
    repeat (3) @(negedge clk);
    check("pre-rst busy", int'(busy_s[0]), 1);
    #2 rst = 1'b1;
    #1 check_reset_outputs("midjob");
    @(negedge clk);
    rst = 1'b0;
    run_job(0, 1'b1, 0, 0, 0, 1'b0);

    for (int j = 0; j < 10; j++)
      run_job(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2, 0, 0,
              1'($urandom_range(0, 1)));

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end
endmodule
